// File: rtl/buzz_seq.sv
// Buzzer beep-pattern sequencer: fixed-priority grant of one requester, then
// N beeps of a square-wave tone, each followed by a silent gap.
module buzz_seq #(
    parameter int NREQ    = 3,
    parameter int CNT_W   = 4,
    parameter int DIV_W   = 16,
    parameter int ON_CYC  = 5000000,
    parameter int OFF_CYC = 5000000,
    parameter int TMR_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CNT_W-1:0]   req_beeps,
    input  logic [NREQ*DIV_W-1:0]   req_div,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic                    out
);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYC - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYC - 1);

    state_t             r_state, w_state_next;
    logic [NREQ-1:0]    r_grant, w_grant_next;
    logic [CNT_W-1:0]   r_beeps, w_beeps_next;
    logic [DIV_W-1:0]   r_div,   w_div_next;
    logic [TMR_W-1:0]   r_tmr,   w_tmr_next;
    logic [DIV_W-1:0]   r_tone,  w_tone_next;
    logic [NREQ-1:0]    r_ack,   w_ack_next;
    logic [NREQ-1:0]    r_done,  w_done_next;
    logic               r_busy,  w_busy_next;
    logic               r_out,   w_out_next;

    // One-hot winner: a requester wins when no lower index is requesting.
    logic [NREQ-1:0]    w_onehot;
    logic [CNT_W-1:0]   w_beeps_m [NREQ];
    logic [DIV_W-1:0]   w_div_m   [NREQ];
    logic [CNT_W-1:0]   w_sel_beeps;
    logic [DIV_W-1:0]   w_sel_div;
    logic               w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pri
            if (gi == 0) begin : g_first
                assign w_onehot[gi] = req[gi];
            end else begin : g_rest
                assign w_onehot[gi] = req[gi] & ~(|req[gi-1:0]);
            end
            assign w_beeps_m[gi] = w_onehot[gi] ? req_beeps[gi*CNT_W +: CNT_W] : '0;
            assign w_div_m[gi]   = w_onehot[gi] ? req_div[gi*DIV_W +: DIV_W]   : '0;
        end
    endgenerate

    assign w_hit = |req;

    always_comb begin
        w_sel_beeps = '0;
        w_sel_div   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_beeps = w_sel_beeps | w_beeps_m[i];
            w_sel_div   = w_sel_div   | w_div_m[i];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_beeps_next = r_beeps;
        w_div_next   = r_div;
        w_tmr_next   = r_tmr;
        w_tone_next  = r_tone;
        w_ack_next   = '0;
        w_done_next  = '0;
        w_busy_next  = r_busy;
        w_out_next   = r_out;
        case (r_state)
            S_IDLE: begin
                if (w_hit) begin
                    w_ack_next = w_onehot;
                    if (w_sel_beeps == '0) begin
                        w_done_next = w_onehot;
                    end else begin
                        w_grant_next = w_onehot;
                        w_beeps_next = w_sel_beeps;
                        w_div_next   = w_sel_div;
                        w_tmr_next   = '0;
                        w_tone_next  = '0;
                        w_out_next   = 1'b0;
                        w_busy_next  = 1'b1;
                        w_state_next = S_ON;
                    end
                end
            end
            S_ON: begin
                if (r_tone == r_div) begin
                    w_out_next  = ~r_out;
                    w_tone_next = '0;
                end else begin
                    w_tone_next = r_tone + DIV_W'(1);
                end
                // End of the tone window overrides any tone toggle this cycle.
                if (r_tmr == ON_LAST) begin
                    w_out_next   = 1'b1;
                    w_beeps_next = r_beeps - CNT_W'(1);
                    w_tmr_next   = '0;
                    w_state_next = S_OFF;
                end else begin
                    w_tmr_next = r_tmr + TMR_W'(1);
                end
            end
            S_OFF: begin
                if (r_tmr == OFF_LAST) begin
                    w_tmr_next = '0;
                    if (r_beeps == '0) begin
                        w_done_next  = r_grant;
                        w_busy_next  = 1'b0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_out_next   = 1'b0;
                        w_tone_next  = '0;
                        w_state_next = S_ON;
                    end
                end else begin
                    w_tmr_next = r_tmr + TMR_W'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_beeps <= '0;
            r_div   <= '0;
            r_tmr   <= '0;
            r_tone  <= '0;
            r_ack   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_out   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_beeps <= w_beeps_next;
            r_div   <= w_div_next;
            r_tmr   <= w_tmr_next;
            r_tone  <= w_tone_next;
            r_ack   <= w_ack_next;
            r_done  <= w_done_next;
            r_busy  <= w_busy_next;
            r_out   <= w_out_next;
        end
    end

    assign ack  = r_ack;
    assign done = r_done;
    assign busy = r_busy;
    assign out  = r_out;

endmodule

// File: tb/tb_buzz_seq.sv
// Directed bench for buzz_seq with short windows (ON=10, OFF=6, beep = 16 cycles).
module tb_buzz_seq;

    localparam int NREQ = 3;
    localparam int CNT_W = 4;
    localparam int DIV_W = 16;
    localparam int ON_C = 10;
    localparam int OFF_C = 6;
    localparam int BEEP_C = ON_C + OFF_C;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] req_beeps;
    logic [NREQ*DIV_W-1:0] req_div;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  out;

    int n_vec  = 0;
    int n_miss = 0;
    int busy_cnt;

    buzz_seq #(
        .NREQ(NREQ), .CNT_W(CNT_W), .DIV_W(DIV_W),
        .ON_CYC(ON_C), .OFF_CYC(OFF_C), .TMR_W(32)
    ) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_beeps(req_beeps), .req_div(req_div),
        .ack(ack), .done(done), .busy(busy), .out(out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observed vector layout: {ack[2:0], done[2:0], busy, out}
    function automatic logic [31:0] obs();
        return {24'b0, ack, done, busy, out};
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] a, input logic [2:0] d,
                                       input logic b, input logic o);
        return {24'b0, a, d, b, o};
    endfunction

    // Checks every cycle after the ack edge up to and including the done edge.
    task automatic body(input int idx, input int nb, input int dv);
        logic [2:0] g;
        logic eo;
        int p;
        g = 3'(1 << idx);
        busy_cnt = busy ? 1 : 0;
        for (int t = 1; t < nb * BEEP_C; t++) begin
            tick();
            p = t % BEEP_C;
            eo = (p < ON_C) ? 1'(((p / (dv + 1)) % 2)) : 1'b1;
            check_vec("body", obs(), mk(3'b0, 3'b0, 1'b1, eo));
            if (busy) busy_cnt++;
        end
        tick();
        check_vec("done", obs(), mk(3'b0, g, 1'b0, 1'b1));
        check_vec("busy_len", 32'(busy_cnt), 32'(nb * BEEP_C));
    endtask

    task automatic play(input int idx, input int nb, input int dv);
        logic [2:0] g;
        g = 3'(1 << idx);
        req_beeps[idx*CNT_W +: CNT_W] = nb[CNT_W-1:0];
        req_div[idx*DIV_W +: DIV_W]   = dv[DIV_W-1:0];
        req[idx] = 1'b1;
        tick();
        if (nb == 0)
            check_vec("ack0", obs(), mk(g, g, 1'b0, 1'b1));
        else
            check_vec("ack", obs(), mk(g, 3'b0, 1'b1, 1'b0));
        req[idx] = 1'b0;
        // Fields changed after the grant must not affect the running pattern.
        req_beeps[idx*CNT_W +: CNT_W] = 4'hF;
        req_div[idx*DIV_W +: DIV_W]   = 16'h0007;
        if (nb != 0) body(idx, nb, dv);
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_beeps = '0;
        req_div   = '0;
        repeat (3) tick();
        check_vec("rst_hold", obs(), mk(3'b0, 3'b0, 1'b0, 1'b1));
        reset = 1'b0;

        for (int c = 0; c < 20; c++) begin
            tick();
            check_vec("idle", obs(), mk(3'b0, 3'b0, 1'b0, 1'b1));
        end

        // Two beeps, div=1: toggle every 2 cycles, done 32 cycles after ack
        play(1, 2, 1);

        // Simultaneous req[0] and req[2]: 0 wins, 2 granted one cycle after done[0]
        req_beeps[0*CNT_W +: CNT_W] = 4'd1;
        req_beeps[2*CNT_W +: CNT_W] = 4'd1;
        req_div[0*DIV_W +: DIV_W]   = 16'd2;
        req_div[2*DIV_W +: DIV_W]   = 16'd2;
        req = 3'b101;
        tick();
        check_vec("arb_ack0", obs(), mk(3'b001, 3'b000, 1'b1, 1'b0));
        req[0] = 1'b0;
        body(0, 1, 2);
        tick();
        check_vec("arb_ack2", obs(), mk(3'b100, 3'b000, 1'b1, 1'b0));
        req[2] = 1'b0;
        body(2, 1, 2);

        // Zero-beep request: ack and done together, stays idle
        tick();
        play(2, 0, 0);
        tick();
        check_vec("zero_after", obs(), mk(3'b0, 3'b0, 1'b0, 1'b1));

        // Reset in the middle of the first ON window of a 3-beep pattern
        req_beeps[0*CNT_W +: CNT_W] = 4'd3;
        req_div[0*DIV_W +: DIV_W]   = 16'd1;
        req[0] = 1'b1;
        tick();
        check_vec("rst_ack", obs(), mk(3'b001, 3'b000, 1'b1, 1'b0));
        req[0] = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            check_vec("rst_pre", obs(), mk(3'b0, 3'b0, 1'b1, 1'(((t / 2) % 2))));
        end
        reset = 1'b1;
        #1;
        check_vec("rst_async", obs(), mk(3'b0, 3'b0, 1'b0, 1'b1));
        for (int c = 0; c < 2; c++) begin
            tick();
            check_vec("rst_in", obs(), mk(3'b0, 3'b0, 1'b0, 1'b1));
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_vec("rst_post", obs(), mk(3'b0, 3'b0, 1'b0, 1'b1));
        end
        play(1, 1, 3);

        // div=0: out alternates every cycle through the ON window
        tick();
        play(0, 1, 0);

        tick();
        check_vec("final_idle", obs(), mk(3'b0, 3'b0, 1'b0, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
